divide_restore: RTL and testbench

- Sequential radix-2 restoring divider.
- It is the inverse of the multiply-add path P = A*B + C: it recovers A (quotient) and C (remainder) from P (dividend) and B (divisor).
- It sits downstream of the multiply-add datapath in the Ch2 arithmetic chain.
- It replaces a DSP-hungry combinational divide with one quotient bit per cycle and a valid/ready handshake on each side.

---
 rtl/divide_restore.sv | 152 +++++++++++++++
 tb/tb_divide_restore.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/divide_restore.sv
// Sequential radix-2 restoring divider producing one quotient bit per enabled cycle.
// Define DIVIDE_RESTORE_SIGNED_EN for two's-complement operands (adds one FIX cycle of latency).
module divide_restore #(
  parameter int DW = 32,
  parameter int VW = 16
) (
  input  logic          clk,
  input  logic          SCLR,
  input  logic          CE,
  input  logic [DW-1:0] DIVIDEND,
  input  logic [VW-1:0] DIVISOR,
  input  logic          IN_VALID,
  output logic          IN_READY,
  output logic [DW-1:0] Q,
  output logic [VW-1:0] R,
  output logic          DIV0,
  output logic          OUT_VALID,
  input  logic          OUT_READY
);
  localparam int CW = $clog2(DW) + 1;
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [VW-1:0] rem, rem_nxt;
  logic [VW:0]   rem_sh;
  logic [DW-1:0] dvd, dvd_nxt, q_nxt;
  logic [VW-1:0] dsr, dsr_nxt, r_nxt;
  logic          div0_nxt, valid_nxt, ge;
`ifdef DIVIDE_RESTORE_SIGNED_EN
  logic          neg_q, neg_q_nxt, neg_r, neg_r_nxt;
`endif

  assign IN_READY = (state == IDLE) & CE & ~SCLR;

  always_ff @(posedge clk) begin
    if (SCLR) begin
      state     <= IDLE;
      count     <= '0;
      rem       <= '0;
      dvd       <= '0;
      dsr       <= '0;
      Q         <= '0;
      R         <= '0;
      DIV0      <= 1'b0;
      OUT_VALID <= 1'b0;
`ifdef DIVIDE_RESTORE_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else if (CE) begin
      state     <= state_nxt;
      count     <= count_nxt;
      rem       <= rem_nxt;
      dvd       <= dvd_nxt;
      dsr       <= dsr_nxt;
      Q         <= q_nxt;
      R         <= r_nxt;
      DIV0      <= div0_nxt;
      OUT_VALID <= valid_nxt;
`ifdef DIVIDE_RESTORE_SIGNED_EN
      neg_q     <= neg_q_nxt;
      neg_r     <= neg_r_nxt;
`endif
    end
  end

  // dvd doubles as the quotient register: dividend bits leave at the top while quotient bits enter at the bottom.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    rem_nxt   = rem;
    dvd_nxt   = dvd;
    dsr_nxt   = dsr;
    q_nxt     = Q;
    r_nxt     = R;
    div0_nxt  = DIV0;
    valid_nxt = OUT_VALID;
`ifdef DIVIDE_RESTORE_SIGNED_EN
    neg_q_nxt = neg_q;
    neg_r_nxt = neg_r;
`endif
    rem_sh = {rem, dvd[DW-1]};
    ge     = (rem_sh >= {1'b0, dsr});

    case (state)
      IDLE: begin
        if (IN_VALID) begin
          state_nxt = RUN;
          count_nxt = '0;
          rem_nxt   = '0;
`ifdef DIVIDE_RESTORE_SIGNED_EN
          dvd_nxt   = DIVIDEND[DW-1] ? -DIVIDEND : DIVIDEND;
          dsr_nxt   = DIVISOR[VW-1] ? -DIVISOR : DIVISOR;
          neg_r_nxt = DIVIDEND[DW-1];
          neg_q_nxt = DIVIDEND[DW-1] ^ DIVISOR[VW-1];
`else
          dvd_nxt   = DIVIDEND;
          dsr_nxt   = DIVISOR;
`endif
        end
      end
      RUN: begin
        if (dsr == '0) begin
          state_nxt = DONE;
          q_nxt     = '1;
          div0_nxt  = 1'b1;
          valid_nxt = 1'b1;
`ifdef DIVIDE_RESTORE_SIGNED_EN
          r_nxt     = neg_r ? -dvd[VW-1:0] : dvd[VW-1:0];
`else
          r_nxt     = dvd[VW-1:0];
`endif
        end else begin
          // When the trial subtract fails the shifted value is below the divisor, so its top bit is zero.
          rem_nxt   = ge ? VW'(rem_sh - {1'b0, dsr}) : rem_sh[VW-1:0];
          dvd_nxt   = {dvd[DW-2:0], ge};
          count_nxt = count + CW'(1);
          if (count == LAST) begin
`ifdef DIVIDE_RESTORE_SIGNED_EN
            state_nxt = FIX;
`else
            state_nxt = DONE;
            q_nxt     = dvd_nxt;
            r_nxt     = rem_nxt;
            div0_nxt  = 1'b0;
            valid_nxt = 1'b1;
`endif
          end
        end
      end
`ifdef DIVIDE_RESTORE_SIGNED_EN
      FIX: begin
        state_nxt = DONE;
        q_nxt     = neg_q ? -dvd : dvd;
        r_nxt     = neg_r ? -rem : rem;
        div0_nxt  = 1'b0;
        valid_nxt = 1'b1;
      end
`endif
      DONE: begin
        if (OUT_READY) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_divide_restore.sv
// Self-checking bench for divide_restore: vector table plus scoreboard, with
// hand-written stall, backpressure and mid-operation reset sequences.
module tb_divide_restore;
  localparam int DW = 32;
  localparam int VW = 16;
`ifdef DIVIDE_RESTORE_SIGNED_EN
  localparam int LAT = DW + 1;
`else
  localparam int LAT = DW;
`endif

  logic          clk = 1'b0;
  logic          SCLR, CE, IN_VALID, IN_READY, DIV0, OUT_VALID, OUT_READY;
  logic [DW-1:0] DIVIDEND, Q;
  logic [VW-1:0] DIVISOR, R;

  typedef struct {
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          div0;
  } vec_t;

  typedef struct {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          div0;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  divide_restore #(.DW(DW), .VW(VW)) dut (
    .clk(clk), .SCLR(SCLR), .CE(CE), .DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .Q(Q), .R(R), .DIV0(DIV0),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [DW-1:0] a, input logic [VW-1:0] b);
    exp_t e;
    logic [DW-1:0] bb;
    bb = DW'(b);
    e.q = a / bb;
    e.r = VW'(a % bb);
    e.div0 = 1'b0;
    return e;
  endfunction

  // Waits for IN_READY, then holds IN_VALID across exactly one accept edge.
  task automatic applyStimulus(input logic [DW-1:0] a, input logic [VW-1:0] b, input exp_t e);
    int n;
    n = 0;
    while (!IN_READY && n < 100) begin
      step();
      n++;
    end
    if (!IN_READY) begin
      tests++;
      fails++;
      $display("[TB] FAIL in_ready_wait: got 0x0, required 0x1");
    end
    DIVIDEND = a;
    DIVISOR  = b;
    IN_VALID = 1'b1;
    sb.push_back(e);
    step();
    IN_VALID = 1'b0;
  endtask

  task automatic waitResult(input string name, input int lat, input int elapsed);
    int   n;
    exp_t e;
    n = elapsed;
    while (!OUT_VALID && n < LAT + 60) begin
      step();
      n++;
    end
    if (!OUT_VALID) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s_timeout: got no OUT_VALID, required OUT_VALID", name);
      sb.delete();
      return;
    end
    checkOutput({name, "_latency"}, 64'(n), 64'(lat));
    e = sb.pop_front();
    checkOutput({name, "_q"}, 64'(Q), 64'(e.q));
    checkOutput({name, "_r"}, 64'(R), 64'(e.r));
    checkOutput({name, "_div0"}, 64'(DIV0), 64'(e.div0));
  endtask

  task automatic consume();
    OUT_READY = 1'b1;
    step();
    checkOutput("out_valid_cleared", 64'(OUT_VALID), 64'd0);
    checkOutput("in_ready_after_done", 64'(IN_READY), 64'd1);
  endtask

  initial begin
    exp_t          e;
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    int            seen;

    SCLR = 1'b1; CE = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
    DIVIDEND = '0; DIVISOR = '0;
    step();
    step();
    checkOutput("in_ready_during_reset", 64'(IN_READY), 64'd0);
    SCLR = 1'b0;
    #1;
    checkOutput("reset_in_ready", 64'(IN_READY), 64'd1);
    checkOutput("reset_out_valid", 64'(OUT_VALID), 64'd0);
    checkOutput("reset_q", 64'(Q), 64'd0);
    checkOutput("reset_r", 64'(R), 64'd0);
    checkOutput("reset_div0", 64'(DIV0), 64'd0);
    CE = 1'b0;
    #1;
    checkOutput("in_ready_ce_low", 64'(IN_READY), 64'd0);
    CE = 1'b1;

    vecs.push_back('{32'd1000, 16'd7, 32'd142, 16'd6, 1'b0});
    vecs.push_back('{32'h12345678, 16'h0000, 32'hFFFFFFFF, 16'h5678, 1'b1});
    vecs.push_back('{32'd100, 16'd10, 32'd10, 16'd0, 1'b0});
    vecs.push_back('{32'd0, 16'd1, 32'd0, 16'd0, 1'b0});
`ifdef DIVIDE_RESTORE_SIGNED_EN
    vecs.push_back('{32'hFFFFFFF9, 16'h0002, 32'hFFFFFFFD, 16'hFFFF, 1'b0});
    vecs.push_back('{32'h80000000, 16'hFFFF, 32'h80000000, 16'h0000, 1'b0});
    vecs.push_back('{32'h00000007, 16'hFFFE, 32'hFFFFFFFD, 16'h0001, 1'b0});
    vecs.push_back('{32'hFFFFFC18, 16'hFFF9, 32'd142, 16'hFFFA, 1'b0});
    vecs.push_back('{32'hFFFFFFFB, 16'h0000, 32'hFFFFFFFF, 16'hFFFB, 1'b1});
`else
    vecs.push_back('{32'hFFFFFFFF, 16'hFFFF, 32'h00010001, 16'h0000, 1'b0});
    vecs.push_back('{32'd5, 16'd9, 32'd0, 16'd5, 1'b0});
    vecs.push_back('{32'hFFFFFFFF, 16'd1, 32'hFFFFFFFF, 16'd0, 1'b0});
    vecs.push_back('{32'h80000000, 16'h8000, 32'h00010000, 16'd0, 1'b0});
    vecs.push_back('{32'd12345678, 16'd1234, 32'd10004, 16'd742, 1'b0});
    vecs.push_back('{32'hFFFFFFFF, 16'd2, 32'h7FFFFFFF, 16'd1, 1'b0});
`endif

    foreach (vecs[i]) begin
      e.q = vecs[i].q;
      e.r = vecs[i].r;
      e.div0 = vecs[i].div0;
      applyStimulus(vecs[i].dividend, vecs[i].divisor, e);
      waitResult($sformatf("vec%0d", i), vecs[i].div0 ? 1 : LAT, 0);
      consume();
    end

`ifndef DIVIDE_RESTORE_SIGNED_EN
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = 16'($urandom_range(1, 65535));
      applyStimulus(a, b, model(a, b));
      waitResult($sformatf("rand%0d", i), LAT, 0);
      consume();
    end
`endif

    // CE low mid-run stretches latency by exactly the stalled cycles.
    e = '{32'd142, 16'd6, 1'b0};
    applyStimulus(32'd1000, 16'd7, e);
    repeat (10) step();
    CE = 1'b0;
    repeat (5) step();
    CE = 1'b1;
    waitResult("stall", LAT + 5, 15);
    consume();

    // Backpressure with a stray IN_VALID that must be ignored while busy.
    OUT_READY = 1'b0;
    applyStimulus(32'd1000, 16'd7, e);
    repeat (3) step();
    DIVIDEND = 32'd55;
    DIVISOR  = 16'd5;
    IN_VALID = 1'b1;
    waitResult("backpressure", LAT, 3);
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("bp_out_valid", 64'(OUT_VALID), 64'd1);
      checkOutput("bp_q_hold", 64'(Q), 64'd142);
      checkOutput("bp_r_hold", 64'(R), 64'd6);
      checkOutput("bp_in_ready", 64'(IN_READY), 64'd0);
    end
    IN_VALID = 1'b0;
    consume();
    repeat (3) step();
    checkOutput("idle_q_hold", 64'(Q), 64'd142);
    checkOutput("idle_r_hold", 64'(R), 64'd6);
    checkOutput("idle_no_stray", 64'(OUT_VALID), 64'd0);

    // Reset mid-operation aborts without a result.
    applyStimulus(32'd1000, 16'd7, e);
    repeat (10) step();
    SCLR = 1'b1;
    step();
    SCLR = 1'b0;
    #1;
    sb.delete();
    checkOutput("abort_in_ready", 64'(IN_READY), 64'd1);
    checkOutput("abort_out_valid", 64'(OUT_VALID), 64'd0);
    checkOutput("abort_q", 64'(Q), 64'd0);
    checkOutput("abort_r", 64'(R), 64'd0);
    checkOutput("abort_div0", 64'(DIV0), 64'd0);
    IN_VALID = 1'b0;
    seen = 0;
    repeat (LAT + 3) begin
      step();
      if (OUT_VALID) seen = 1;
    end
    checkOutput("abort_no_output", 64'(seen), 64'd0);
    e = '{32'd10, 16'd0, 1'b0};
    applyStimulus(32'd100, 16'd10, e);
    waitResult("after_abort", LAT, 0);
    consume();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
